variable_rshift_pipeline: RTL and testbench
===========================================

# variable_rshift_pipeline

Pipelined variable right barrel shifter: the inverse-direction companion of the left-shift pipeline, used to renormalise data that was scaled up by the left shifter. Decomposes the shift amount bitwise into one registered conditional-shift stage per bit, and carries a valid/ready handshake with full-pipeline stall. Also reports a sticky flag, the OR of every bit shifted out, for downstream rounding.

## Interface
- DATA_W, 8, data width of `a` / `shifted_a`
- SHW_W, 3, shift-amount width; also the number of pipeline stages (max shift 2^SHW_W-1)

- CLK  in  1  system clock, rising-edge
- RST  in  1  reset, asynchronous, active-low
- in_valid  in  1  `a`/`shift_width` carry a request
- in_ready  out  1  pipeline can accept this cycle
- a  in  DATA_W  operand
- shift_width  in  SHW_W  right-shift amount, 0..2^SHW_W-1
- out_valid  out  1  `shifted_a`/`sticky` valid
- out_ready  in  1  consumer accepts this cycle
- shifted_a  out  DATA_W  a >> shift_width
- sticky  out  1  OR of all bits discarded by the shift

## Operation
- Stage k (k = 0..SHW_W-1) registers data, the remaining shift bits, a sticky accumulator and a valid bit.
  - When its shift bit k is 1, the stage shifts right by 2^k.
  - It ORs the 2^k discarded LSBs into sticky.
- Stage 0 takes `a` and `shift_width` directly. The last stage's registers drive the outputs.
- stall = out_valid & ~out_ready.
  - When stall is 1, every stage holds.
  - When stall is 0, every stage loads from its predecessor.
  - Stage 0 loads in_valid from the input.
- in_ready = ~stall, combinational.
- A transfer occurs on an edge where in_valid & in_ready.
- An output is consumed on an edge where out_valid & out_ready.
- Bubbles (in_valid=0) propagate as valid=0. Data registers may load don't-care when valid=0.
- Logical fill: vacated MSBs are 0.
- Boundary behaviour:
  - shift_width=0: data passes unchanged, sticky=0.
  - Maximum shift: only the top bit survives (logical mode).
  - a=0: sticky=0 for any shift.
  - Simultaneous accept-in and consume-out while full: both happen on the same edge, with no loss and no duplication.

## Timing
- Reset (asynchronous assert, any time including mid-stream):
  - All valid bits, data, sticky and shift registers clear immediately.
  - Outputs after reset: out_valid=0, shifted_a=0, sticky=0.
  - in_ready=1 after reset, because stall=0.
  - In-flight items are dropped.
- Latency is SHW_W cycles. For an item accepted at edge N with no stall, out_valid=1 after edge N+SHW_W-1. With the default SHW_W=3, that is after edge N+2.
- Throughput: one item per clock while out_ready=1.
- Outputs are stable while out_valid & ~out_ready.
- Each cycle of out_ready=0 with out_valid=1 adds exactly one cycle to every in-flight item.

## Configuration
- ARITH_SHIFT_EN
  - Defined: vacated MSBs are filled with a[DATA_W-1] (arithmetic shift). sticky is computed identically.
  - Undefined: logical shift with zero fill.
- Only fill values differ. Latency and handshake behaviour are identical in both modes.

## Structure
- Package variable_shift_pkg holds:
  - DATA_W/SHW_W defaults, shared with the left-shift pipeline.
  - A stage-record typedef {valid, data, shw_rem, sticky}.
- Sub-module rshift_stage: one registered conditional right-shift by a fixed 2^k.
  - Inputs: the stall/enable, the fill bit, and the predecessor's record.
  - Instantiated SHW_W times via generate.

## Test plan
- Single item, logical mode: a=8'hB4, shift_width=3.
  - Result after edge N+2: shifted_a=8'h16, sticky=1, out_valid high for one cycle.
  - With ARITH_SHIFT_EN: shifted_a=8'hF6.
- Extremes:
  - a=8'h80, shift_width=7 → 8'h01, sticky=0. With ARITH_SHIFT_EN → 8'hFF.
  - a=8'h5A, shift_width=0 → 8'h5A, sticky=0.
- 16-bit counter sweep:
  - Drive a=cnt[7:0], shift_width=cnt[10:8], in_valid=1, out_ready=1 for 2048 cycles.
  - Every output must equal (cnt[7:0]>>cnt[10:8]) from 3 items earlier.
  - sticky must be 1 exactly when the discarded bits are nonzero.
- Backpressure: stream 4 items and hold out_ready=0 for 3 cycles once out_valid rises.
  - in_ready=0 and outputs stable during the hold.
  - All 4 results are delivered in order, none lost or duplicated.
- Mid-stream reset: assert RST low for 7 ns mid-cycle with 3 items in flight.
  - out_valid=0 and shifted_a=0 immediately.
  - No stale item appears after release.
  - The first item after release arrives with 3-cycle latency.

Source files
------------

// File: rtl/variable_shift_pkg.sv
// Shared definitions for the variable shift pipelines: default widths and the
// per-stage pipeline record.
package variable_shift_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SHW_W_DEF  = 3;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
    logic [SHW_W_DEF-1:0]  shw_rem;
    logic                  sticky;
  } stage_rec_t;

endpackage

// File: rtl/rshift_stage.sv
// One registered pipeline stage: conditionally shifts right by 2^K when shift
// bit K of the record is set, folding the discarded LSBs into sticky.
module rshift_stage
  import variable_shift_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  K      = 0,
  parameter type rec_t  = stage_rec_t
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_stall,
  input  logic i_fill,
  input  rec_t i_rec,
  output rec_t o_rec
);

  localparam int SH = 1 << K;
  localparam logic [DATA_W-1:0] LOW_MASK = ~({DATA_W{1'b1}} << SH);

  rec_t w_next;
  rec_t r_rec;

  // Fill with ones is done as complement-shift-complement so no slicing
  // by 2^K is needed even when 2^K reaches DATA_W.
  always_comb begin
    w_next = i_rec;
    if (i_rec.shw_rem[K]) begin
      w_next.data   = i_fill ? ~(~i_rec.data >> SH) : (i_rec.data >> SH);
      w_next.sticky = i_rec.sticky | (|(i_rec.data & LOW_MASK));
    end
  end

  // NOTE: the whole record is cleared on reset, not just valid, so the
  // outputs read zero while reset is asserted and no stale data survives.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rec <= '0;
    end else if (!i_stall) begin
      r_rec <= w_next;
    end
  end

  assign o_rec = r_rec;

endmodule

// File: rtl/variable_rshift_pipeline.sv
// Pipelined variable right barrel shifter with valid/ready and sticky output.
// Define ARITH_SHIFT_EN for arithmetic (sign) fill; default is zero fill.
module variable_rshift_pipeline
  import variable_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHW_W  = SHW_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [SHW_W-1:0]  shift_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] shifted_a,
  output logic              sticky
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [SHW_W-1:0]  shw_rem;
    logic              sticky;
  } rec_t;

  rec_t w_head;
  rec_t w_stage [SHW_W];
  logic w_stall;

  // A single stall freezes every stage, so bubbles are never squeezed out.
  assign w_stall  = w_stage[SHW_W-1].valid & ~out_ready;
  assign in_ready = ~w_stall;

  always_comb begin
    w_head         = '0;
    w_head.valid   = in_valid;
    w_head.data    = a;
    w_head.shw_rem = shift_width;
  end

  genvar k;
  generate
    for (k = 0; k < SHW_W; k++) begin : g_stage
      rec_t w_in;
      logic w_fill;

      if (k == 0) begin : g_first
        assign w_in = w_head;
      end else begin : g_rest
        assign w_in = w_stage[k-1];
      end

`ifdef ARITH_SHIFT_EN
      // Earlier arithmetic stages keep the sign in the MSB, so it is the fill.
      assign w_fill = w_in.data[DATA_W-1];
`else
      assign w_fill = 1'b0;
`endif

      rshift_stage #(
        .DATA_W (DATA_W),
        .K      (k),
        .rec_t  (rec_t)
      ) u_stage (
        .CLK     (CLK),
        .RST     (RST),
        .i_stall (w_stall),
        .i_fill  (w_fill),
        .i_rec   (w_in),
        .o_rec   (w_stage[k])
      );
    end
  endgenerate

  assign out_valid = w_stage[SHW_W-1].valid;
  assign shifted_a = w_stage[SHW_W-1].data;
  assign sticky    = w_stage[SHW_W-1].sticky;

endmodule

// File: tb/tb_variable_rshift_pipeline.sv
// Directed bench for variable_rshift_pipeline (DATA_W=8, SHW_W=3); follows
// ARITH_SHIFT_EN for the expected fill.
module tb_variable_rshift_pipeline;

`ifdef ARITH_SHIFT_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [2:0] shift_width = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] shifted_a;
  logic       sticky;

  int n_vec  = 0;
  int n_miss = 0;
  int n_pop  = 0;
  bit mon_en = 1'b0;
  logic [8:0] sb_q [$];
  logic [8:0] sb_exp;

  always #5 CLK = ~CLK;

  variable_rshift_pipeline dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .shift_width (shift_width),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shifted_a   (shifted_a),
    .sticky      (sticky)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: returns {sticky, shifted}.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [2:0] sv);
    logic [7:0] d;
    logic [7:0] m;
    if (ARITH) d = $signed(av) >>> sv;
    else       d = av >> sv;
    m = 8'hFF >> (4'd8 - {1'b0, sv});
    return {|(av & m), d};
  endfunction

  // Scoreboard: looks at the handshake half a cycle before the edge that acts on it.
  always @(negedge CLK) begin
    if (mon_en && RST) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("out_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("stream_result", {23'd0, sticky, shifted_a}, {23'd0, sb_exp});
          n_pop++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(a, shift_width));
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [2:0] sh;
    logic [7:0] exp_log;
    logic [7:0] exp_ari;
    logic       exp_s;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    @(posedge CLK); #1;
    in_valid = 1'b1; a = v.a; shift_width = v.sh; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge CLK);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check("latency", lat, 3);
    check("shifted_a", {24'd0, shifted_a}, {24'd0, ARITH ? v.exp_ari : v.exp_log});
    check("sticky", {31'd0, sticky}, {31'd0, v.exp_s});
    @(negedge CLK);
    check("valid_pulse", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [8:0] snap;
    int stale;

    vecs[0] = '{8'hB4, 3'd3, 8'h16, 8'hF6, 1'b1};
    vecs[1] = '{8'h80, 3'd7, 8'h01, 8'hFF, 1'b0};
    vecs[2] = '{8'h5A, 3'd0, 8'h5A, 8'h5A, 1'b0};
    vecs[3] = '{8'hFF, 3'd4, 8'h0F, 8'hFF, 1'b1};
    vecs[4] = '{8'h00, 3'd5, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h7F, 3'd7, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{8'h01, 3'd1, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{8'hC3, 3'd2, 8'h30, 8'hF0, 1'b1};
    vecs[8] = '{8'h40, 3'd6, 8'h01, 8'h01, 1'b0};
    vecs[9] = '{8'hA5, 3'd1, 8'h52, 8'hD2, 1'b1};

    #1 RST = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_shifted_a", {24'd0, shifted_a}, 32'd0);
    check("rst_sticky", {31'd0, sticky}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Full-rate sweep of every (a, shift) pair.
    mon_en = 1'b1;
    n_pop  = 0;
    for (int cnt = 0; cnt < 2048; cnt++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1; a = 8'(cnt); shift_width = 3'(cnt >> 8); out_ready = 1'b1;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (6) @(negedge CLK);
    check("sweep_drained", sb_q.size(), 0);
    check("sweep_count", n_pop, 2048);

    // Backpressure: 4 items, out_ready low for 3 cycles once out_valid rises.
    n_pop = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      a = (i == 0) ? 8'hB4 : (i == 1) ? 8'h7F : 8'h81;
      shift_width = (i == 0) ? 3'd3 : (i == 1) ? 3'd1 : 3'd5;
    end
    @(posedge CLK); #1;
    in_valid = 1'b1; a = 8'hC6; shift_width = 3'd2; out_ready = 1'b0;
    @(negedge CLK);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head", {23'd0, sticky, shifted_a}, {23'd0, model(8'hB4, 3'd3)});
    snap = {sticky, shifted_a};
    repeat (2) begin
      @(negedge CLK);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_stable", {23'd0, sticky, shifted_a}, {23'd0, snap});
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (8) @(negedge CLK);
    check("bp_drained", sb_q.size(), 0);
    check("bp_count", n_pop, 4);

    // Mid-stream reset with three items in flight.
    mon_en = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1; out_ready = 1'b1; a = 8'hF0 + 8'(i); shift_width = 3'(i);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #1 RST = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_shifted_a", {24'd0, shifted_a}, 32'd0);
    check("midrst_sticky", {31'd0, sticky}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    #6 RST = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge CLK);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
